count_match_unit: RTL

COUNT_MATCH_UNIT -- requirements
Module: count_match_unit

---
 rtl/cmu_pkg.sv | 31 +++
 rtl/cmu_evt_slot.sv | 43 ++++
 rtl/count_match_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cmu_pkg.sv
// Shared types and constants for the count match unit: FSM states, event kinds
// and event-record field positions.
package cmu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PEND  = 2'd2
   } cmu_state_e;

   localparam int unsigned KIND_W  = 2;
   localparam int unsigned EXTRA_W = 3;

   localparam logic [KIND_W-1:0] KIND_MATCH = 2'b00;
   localparam logic [KIND_W-1:0] KIND_WRAP  = 2'b01;
   localparam logic [KIND_W-1:0] KIND_JUMP  = 2'b10;

   // Event record layout: {kind[1:0], dir, value[w-1:0]}
   function automatic int unsigned rec_w(input int unsigned w);
      return w + EXTRA_W;
   endfunction

   function automatic int unsigned dir_pos(input int unsigned w);
      return w;
   endfunction

   function automatic int unsigned kind_lo(input int unsigned w);
      return w + 1;
   endfunction

endpackage

// File: rtl/cmu_evt_slot.sv
// Single-entry event output register with valid/ready handshake and a
// saturating counter of dropped events.
module cmu_evt_slot #(
   parameter int unsigned REC_W  = 19,
   parameter int unsigned MISS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              flush,
   input  logic [REC_W-1:0]  rec_in,
   input  logic              miss_inc,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [REC_W-1:0]  evt_data,
   output logic [MISS_W-1:0] miss_cnt,
   output logic              accept_c
);

   assign accept_c = evt_valid & evt_ready;

   // A load in the same cycle as an accept replaces the record in place
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evt_valid <= 1'b0;
         evt_data  <= '0;
      end else if (load) begin
         evt_valid <= 1'b1;
         evt_data  <= rec_in;
      end else if (flush || accept_c) begin
         evt_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         miss_cnt <= '0;
      end else if (miss_inc && (miss_cnt != '1)) begin
         miss_cnt <= miss_cnt + MISS_W'(1);
      end
   end

endmodule

// File: rtl/count_match_unit.sv
// Compares a live counter value against a programmable compare register and
// emits event records through a one-entry slot. Wrap events: CMU_WRAP_DETECT_EN.
module count_match_unit
   import cmu_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned MISS_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    count,
   input  logic [WIDTH-1:0]    cmp_val,
   input  logic                cmp_wr,
   input  logic                arm,
   input  logic                disarm,
   input  logic                oneshot,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [WIDTH+2:0]    evt_data,
   output logic                armed,
   output logic [MISS_W-1:0]   miss_cnt
);

   localparam int unsigned REC_W   = rec_w(WIDTH);
   localparam int unsigned DIR_POS = dir_pos(WIDTH);
   localparam int unsigned KIND_LO = kind_lo(WIDTH);

   cmu_state_e state_q, state_d;

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] cmp_q;
   logic             moved_c, step_up_c, step_dn_c;
   logic             match_c, wrap_c, evt_c, collide_c;
   logic [REC_W-1:0] rec_c;
   logic             slot_load_c, slot_flush_c, miss_inc_c, accept_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         cmp_q   <= '0;
      end else begin
         count_q <= count;
         if (cmp_wr) cmp_q <= cmp_val;
      end
   end

   // Detection: only a changing count can match, so a held value never retriggers
   assign moved_c   = (count != count_q);
   assign step_up_c = (count == count_q + WIDTH'(1));
   assign step_dn_c = (count == count_q - WIDTH'(1));
   assign match_c   = moved_c && (count == cmp_q);

`ifdef CMU_WRAP_DETECT_EN
   assign wrap_c = ((count_q == '1) && (count == '0)) ||
                   ((count_q == '0) && (count == '1));
`else
   assign wrap_c = 1'b0;
`endif

   assign evt_c     = wrap_c | match_c;
   assign collide_c = wrap_c & match_c;

   // Wrap steps are also unit steps, so dir follows step_up_c in every case
   always_comb begin
      rec_c                   = '0;
      rec_c[WIDTH-1:0]        = count;
      rec_c[DIR_POS]          = step_up_c;
      if (wrap_c)
         rec_c[KIND_LO +: KIND_W] = KIND_WRAP;
      else if (step_up_c || step_dn_c)
         rec_c[KIND_LO +: KIND_W] = KIND_MATCH;
      else
         rec_c[KIND_LO +: KIND_W] = KIND_JUMP;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         armed   <= 1'b0;
      end else begin
         state_q <= state_d;
         armed   <= (state_d != ST_IDLE);
      end
   end

   always_comb begin
      state_d      = state_q;
      slot_load_c  = 1'b0;
      slot_flush_c = 1'b0;
      miss_inc_c   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arm && !disarm) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (disarm) begin
               state_d = ST_IDLE;
            end else if (evt_c) begin
               state_d     = ST_PEND;
               slot_load_c = 1'b1;
               miss_inc_c  = collide_c;
            end
         end
         ST_PEND: begin
            if (disarm) begin
               state_d      = ST_IDLE;
               slot_flush_c = 1'b1;
            end else if (accept_c) begin
               // oneshot ends the session; a coincident new event is not recorded
               if (oneshot) begin
                  state_d = ST_IDLE;
               end else if (evt_c) begin
                  slot_load_c = 1'b1;
                  miss_inc_c  = collide_c;
               end else begin
                  state_d = ST_ARMED;
               end
            end else if (evt_c) begin
               miss_inc_c = 1'b1;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            slot_flush_c = 1'b1;
         end
      endcase
   end

   cmu_evt_slot #(
      .REC_W  (REC_W),
      .MISS_W (MISS_W)
   ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (slot_load_c),
      .flush     (slot_flush_c),
      .rec_in    (rec_c),
      .miss_inc  (miss_inc_c),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .miss_cnt  (miss_cnt),
      .accept_c  (accept_c)
   );

endmodule
